// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for a 5-stage accumulator pipeline: RAW hazard
// stalls from an EX/MEM/WB shadow tracker, plus start/HLT-drain/halt/resume lifecycle.
module pipe_hazard_ctrl #(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resume,
  input  logic             mem_busy,
  input  logic             id_valid,
  input  logic [2:0]       id_opcode,
  input  logic [4:0]       id_ad1,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             pipe_en,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_valid;
  logic [2:0]       r_wr_reg;
  logic [2:0]       r_wr_acc;
  logic [2:0]       r_is_hlt;
  logic [4:0]       r_dest [0:2];
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_rd_reg, w_rd_acc, w_wr_reg, w_wr_acc, w_is_hlt;
  logic [2:0] w_reg_hit, w_acc_hit;
  logic       w_hazard, w_issue, w_stall;

  always_comb begin
    w_rd_reg = (id_opcode == 3'b011) || (id_opcode == 3'b100) || (id_opcode == 3'b101);
    w_rd_acc = (id_opcode == 3'b101) || (id_opcode == 3'b110);
    w_wr_reg = (id_opcode == 3'b001) || (id_opcode == 3'b010) || (id_opcode == 3'b110);
    w_wr_acc = (id_opcode == 3'b100) || (id_opcode == 3'b101);
    w_is_hlt = (id_opcode == 3'b111);
  end

  // The WB entry only matters when the register file is not write-through.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    localparam bit CHK = (gi < 2) || (WB_BYPASS == 0);
    assign w_reg_hit[gi] = CHK && r_valid[gi] && r_wr_reg[gi] && (r_dest[gi] == id_ad1);
    assign w_acc_hit[gi] = CHK && r_valid[gi] && r_wr_acc[gi];
  end

  assign w_hazard = id_valid && ((w_rd_reg && (|w_reg_hit)) || (w_rd_acc && (|w_acc_hit)));
  assign w_stall  = (r_state == S_RUN) && !mem_busy && w_hazard;
  assign w_issue  = (r_state == S_RUN) && !mem_busy && !w_hazard && id_valid;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    pipe_en      = 1'b1;
    id_ex_bubble = 1'b1;
    busy         = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_RUN: begin
        busy = 1'b1;
        if (mem_busy) begin
          pipe_en      = 1'b0;
          id_ex_bubble = 1'b0;
        end else if (!w_hazard) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_bubble = 1'b0;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        pipe_en = !mem_busy;
      end
      default: begin
        pipe_en = 1'b0;
        halted  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_wr_reg    <= '0;
      r_wr_acc    <= '0;
      r_is_hlt    <= '0;
      r_dest[0]   <= '0;
      r_dest[1]   <= '0;
      r_dest[2]   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (pipe_en) begin
        r_valid   <= {r_valid[1:0],  w_issue};
        r_wr_reg  <= {r_wr_reg[1:0], w_issue && w_wr_reg};
        r_wr_acc  <= {r_wr_acc[1:0], w_issue && w_wr_acc};
        r_is_hlt  <= {r_is_hlt[1:0], w_issue && w_is_hlt};
        r_dest[2] <= r_dest[1];
        r_dest[1] <= r_dest[0];
        r_dest[0] <= w_issue ? id_ad1 : 5'd0;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        S_IDLE:   if (start) r_state <= S_RUN;
        S_RUN:    if (w_issue && w_is_hlt) r_state <= S_DRAIN;
        S_DRAIN:  if (r_valid[2] && r_is_hlt[2] && !mem_busy) r_state <= S_HALTED;
        default:  if (resume) r_state <= S_RUN;
      endcase
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences and random
// stimulus checked against a distance-in-pipeline reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, resume, mem_busy, id_valid;
  logic [2:0] id_opcode;
  logic [4:0] id_ad1;
  logic [2:0] pc_en, if_id_en, pipe_en, bub, busy, halted;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  // dut 0: bypass, 16-bit count; dut 1: no bypass; dut 2: bypass, 2-bit count
  pipe_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .resume(resume), .mem_busy(mem_busy),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_ad1(id_ad1),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .pipe_en(pipe_en[0]),
    .id_ex_bubble(bub[0]), .busy(busy[0]), .halted(halted[0]), .stall_cnt(cnt_a));
  pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .resume(resume), .mem_busy(mem_busy),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_ad1(id_ad1),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .pipe_en(pipe_en[1]),
    .id_ex_bubble(bub[1]), .busy(busy[1]), .halted(halted[1]), .stall_cnt(cnt_b));
  pipe_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .start(start), .resume(resume), .mem_busy(mem_busy),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_ad1(id_ad1),
    .pc_en(pc_en[2]), .if_id_en(if_id_en[2]), .pipe_en(pipe_en[2]),
    .id_ex_bubble(bub[2]), .busy(busy[2]), .halted(halted[2]), .stall_cnt(cnt_c));

  typedef struct {
    logic       rst, start, resume, mb, valid;
    logic [2:0] op;
    logic [4:0] ad;
    logic       pc, pipe, bub, busy, hlt;
    int         cnt;
  } vec_t;

  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_HALT = 3;

  // Model: ptime counts pipeline advances; an instruction issued at ptime p is
  // (ptime - p) stages past ID (1=EX, 2=MEM, 3=WB).
  int st [3];
  int ptime [3];
  int last_reg [3][32];
  int last_acc [3];
  int last_hlt [3];
  int cnt [3];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic s, logic rs, logic mb, logic v,
                              logic [2:0] op, logic [4:0] ad, logic pc, logic pp,
                              logic bb, logic bz, logic hl, int c);
    vec_t t;
    t.rst = r; t.start = s; t.resume = rs; t.mb = mb; t.valid = v; t.op = op; t.ad = ad;
    t.pc = pc; t.pipe = pp; t.bub = bb; t.busy = bz; t.hlt = hl; t.cnt = c;
    return t;
  endfunction

  function automatic bit m_hz(int k);
    int lim = (k == 1) ? 3 : 2;
    bit rr = (id_opcode == 3'b011) || (id_opcode == 3'b100) || (id_opcode == 3'b101);
    bit ra = (id_opcode == 3'b101) || (id_opcode == 3'b110);
    return id_valid && ((rr && (ptime[k] - last_reg[k][id_ad1] <= lim)) ||
                        (ra && (ptime[k] - last_acc[k] <= lim)));
  endfunction

  // {pc_en, if_id_en, pipe_en, bubble, busy, halted}
  function automatic logic [5:0] m_out(int k);
    case (st[k])
      S_IDLE:  return 6'b001100;
      S_RUN:   if (mem_busy) return 6'b000010;
               else if (m_hz(k)) return 6'b001110;
               else return 6'b111010;
      S_DRAIN: return {2'b00, !mem_busy, 3'b110};
      default: return 6'b000101;
    endcase
  endfunction

  function automatic logic [5:0] d_out(int k);
    return {pc_en[k], if_id_en[k], pipe_en[k], bub[k], busy[k], halted[k]};
  endfunction

  function automatic int d_cnt(int k);
    if (k == 0) return int'(cnt_a);
    if (k == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  task automatic m_step();
    for (int k = 0; k < 3; k++) begin
      logic [5:0] o = m_out(k);
      bit hz = m_hz(k);
      bit iss = (st[k] == S_RUN) && !mem_busy && !hz && id_valid;
      int cmax = (k == 2) ? 3 : 65535;
      int pt = ptime[k];
      if (rst) begin
        st[k] = S_IDLE; ptime[k] = 0; cnt[k] = 0;
        last_acc[k] = -100; last_hlt[k] = -100;
        for (int r = 0; r < 32; r++) last_reg[k][r] = -100;
      end else begin
        if (iss) begin
          if (id_opcode inside {3'b001, 3'b010, 3'b110}) last_reg[k][id_ad1] = pt;
          if (id_opcode inside {3'b100, 3'b101}) last_acc[k] = pt;
          if (id_opcode == 3'b111) last_hlt[k] = pt;
        end
        if (o[3]) ptime[k] = pt + 1;
        if ((st[k] == S_RUN) && !mem_busy && hz && (cnt[k] < cmax)) cnt[k] = cnt[k] + 1;
        case (st[k])
          S_IDLE:  if (start) st[k] = S_RUN;
          S_RUN:   if (iss && id_opcode == 3'b111) st[k] = S_DRAIN;
          S_DRAIN: if (!mem_busy && (pt - last_hlt[k] == 3)) st[k] = S_HALT;
          default: if (resume) st[k] = S_RUN;
        endcase
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(vec_t v, bit use_exp, int idx);
    rst = v.rst; start = v.start; resume = v.resume; mem_busy = v.mb;
    id_valid = v.valid; id_opcode = v.op; id_ad1 = v.ad;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("model dut%0d step%0d", k, idx), {d_out(k), 16'(d_cnt(k))},
          {m_out(k), 16'(cnt[k])});
    if (use_exp) begin
      chk($sformatf("table step%0d", idx),
          {pc_en[0], pipe_en[0], bub[0], busy[0], halted[0], cnt_a},
          {v.pc, v.pipe, v.bub, v.busy, v.hlt, 16'(v.cnt)});
      $display("vec %0d: pc=%0b pipe=%0b bub=%0b busy=%0b halt=%0b cnt=%0d",
               idx, pc_en[0], pipe_en[0], bub[0], busy[0], halted[0], cnt_a);
    end
    m_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    // rst st rs mb v op ad | pc pipe bub busy hlt cnt
    tbl.push_back(mk(1,0,0,0,0,3'd0,5'd0, 0,1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,3'd0,5'd0, 0,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,3'd1,5'd3, 1,1,0,1,0,0)); // LDO r3
    tbl.push_back(mk(0,0,0,0,1,3'd3,5'd3, 0,1,1,1,0,0)); // STO r3 stalls
    tbl.push_back(mk(0,0,0,0,1,3'd3,5'd3, 0,1,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,1,3'd3,5'd3, 1,1,0,1,0,2));
    tbl.push_back(mk(0,0,0,0,1,3'd3,5'd4, 1,1,0,1,0,2));
    tbl.push_back(mk(0,0,0,0,1,3'd1,5'd3, 1,1,0,1,0,2)); // LDO r3, STO r4
    tbl.push_back(mk(0,0,0,0,1,3'd3,5'd4, 1,1,0,1,0,2));
    tbl.push_back(mk(0,0,0,0,1,3'd4,5'd1, 1,1,0,1,0,2)); // PRE r1, LDM r5
    tbl.push_back(mk(0,0,0,0,1,3'd6,5'd5, 0,1,1,1,0,2));
    tbl.push_back(mk(0,0,0,0,1,3'd6,5'd5, 0,1,1,1,0,3));
    tbl.push_back(mk(0,0,0,0,1,3'd6,5'd5, 1,1,0,1,0,4));
    tbl.push_back(mk(0,0,0,0,1,3'd0,5'd0, 1,1,0,1,0,4)); // NOP NOP HLT
    tbl.push_back(mk(0,0,0,0,1,3'd0,5'd0, 1,1,0,1,0,4));
    tbl.push_back(mk(0,0,0,0,1,3'd7,5'd0, 1,1,0,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,1,1,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,1,1,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,1,1,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,0,1,0,1,4)); // halted at t+4
    tbl.push_back(mk(0,1,0,0,0,3'd0,5'd0, 0,0,1,0,1,4)); // start ignored
    tbl.push_back(mk(0,0,1,0,0,3'd0,5'd0, 0,0,1,0,1,4)); // resume
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 1,1,0,1,0,4));
    tbl.push_back(mk(0,0,0,0,1,3'd4,5'd2, 1,1,0,1,0,4)); // PRE r2, ADD r2
    tbl.push_back(mk(0,0,0,0,1,3'd5,5'd2, 0,1,1,1,0,4));
    tbl.push_back(mk(0,0,0,1,1,3'd5,5'd2, 0,0,0,1,0,5)); // mem_busy freeze
    tbl.push_back(mk(0,0,0,1,1,3'd5,5'd2, 0,0,0,1,0,5));
    tbl.push_back(mk(0,0,0,1,1,3'd5,5'd2, 0,0,0,1,0,5));
    tbl.push_back(mk(0,0,0,0,1,3'd5,5'd2, 0,1,1,1,0,5));
    tbl.push_back(mk(0,0,0,0,1,3'd5,5'd2, 1,1,0,1,0,6));
    tbl.push_back(mk(0,0,0,0,1,3'd1,5'd7, 1,1,0,1,0,6)); // fill tracker
    tbl.push_back(mk(0,0,0,0,1,3'd2,5'd8, 1,1,0,1,0,6));
    tbl.push_back(mk(1,0,0,0,1,3'd1,5'd9, 1,1,0,1,0,6)); // reset mid-RUN
    tbl.push_back(mk(1,0,0,0,1,3'd1,5'd9, 0,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,1,1,0,0,0));

    rst = 1'b1; start = 1'b0; resume = 1'b0; mem_busy = 1'b0;
    id_valid = 1'b0; id_opcode = 3'd0; id_ad1 = 5'd0;
    m_step();
    @(posedge clk);
    #1;

    foreach (tbl[i]) cycle(tbl[i], 1'b1, i);

    // Register RAW on all three configurations, then an acc hazard that saturates dut 2.
    seq.push_back(mk(1,0,0,0,0,3'd0,5'd0, 0,0,0,0,0,0));
    seq.push_back(mk(0,1,0,0,0,3'd0,5'd0, 0,0,0,0,0,0));
    seq.push_back(mk(0,0,0,0,1,3'd1,5'd3, 0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) seq.push_back(mk(0,0,0,0,1,3'd3,5'd3, 0,0,0,0,0,0));
    seq.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,0,0,0,0,0));
    foreach (seq[i]) cycle(seq[i], 1'b0, 100 + i);
    chk("raw bypass stall_cnt", 32'(cnt_a), 32'd2);
    chk("raw no-bypass stall_cnt", 32'(cnt_b), 32'd3);
    $display("seq raw: cnt_a=%0d cnt_b=%0d cnt_c=%0d", cnt_a, cnt_b, cnt_c);
    seq.delete();
    seq.push_back(mk(0,0,0,0,1,3'd4,5'd1, 0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) seq.push_back(mk(0,0,0,0,1,3'd5,5'd1, 0,0,0,0,0,0));
    seq.push_back(mk(0,0,0,0,0,3'd0,5'd0, 0,0,0,0,0,0));
    foreach (seq[i]) cycle(seq[i], 1'b0, 200 + i);
    chk("acc bypass stall_cnt", 32'(cnt_a), 32'd4);
    chk("acc no-bypass stall_cnt", 32'(cnt_b), 32'd6);
    chk("saturated stall_cnt", 32'(cnt_c), 32'd3);
    $display("seq sat: cnt_a=%0d cnt_b=%0d cnt_c=%0d", cnt_a, cnt_b, cnt_c);

    for (int i = 0; i < 800; i++) begin
      vec_t v;
      v = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0);
      cycle(v, 1'b0, 1000 + i);
      $display("rnd %0d: op=%0d ad=%0d mb=%0b pc=%0b%0b%0b cnt=%0d/%0d/%0d", i,
               v.op, v.ad, v.mb, pc_en[0], pc_en[1], pc_en[2], cnt_a, cnt_b, cnt_c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage accumulator pipeline (IF, ID, EX, MEM, WB).
- Watches the instruction currently in ID and tracks in-flight writers in EX/MEM/WB with an internal 3-entry shadow pipeline.
- Generates PC/IF_ID/pipeline enables and ID/EX bubble insertion to resolve register-file and accumulator RAW hazards.
- Owns the start / HLT-drain / halted / resume lifecycle and counts hazard stall cycles.

Parameters:
- WB_BYPASS, 1, 1 = register file is write-through (WB write visible to same-cycle ID read), so the WB entry is not a hazard; 0 = WB entry is also checked.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- resume  in  1  leave HALTED and continue fetching
- mem_busy  in  1  data memory wait; freezes the whole pipeline
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  3  opcode in ID
- id_ad1  in  5  register field in ID
- pc_en  out  1  PC advance enable
- if_id_en  out  1  IF_ID register load enable
- pipe_en  out  1  load enable for ID_EX, EX_MEM, MEM_WB
- id_ex_bubble  out  1  load NOP (opcode 000, write enables 0) into ID_EX instead of the ID result
- busy  out  1  state is RUN or DRAIN
- halted  out  1  state is HALTED
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Opcode classes:
  - reg writers: LDO 001, LDA 010, LDM 110.
  - acc writers: PRE 100, ADD 101.
  - reg readers: STO 011, PRE 100, ADD 101.
  - acc readers: ADD 101, LDM 110.
  - NOP 000 and HLT 111 read and write nothing.
- Tracker: entries E0 (EX), E1 (MEM), E2 (WB). Each entry holds {valid, wr_reg, wr_acc, is_hlt, dest[4:0]}.
  - When pipe_en=1: E2<=E1, E1<=E0, and E0<=decoded ID instruction if issuing, else an invalid entry.
  - When pipe_en=0: tracker holds.
- Hazard (combinational) requires id_valid=1 and either:
  - a reg reader where some valid checked entry has wr_reg=1 and dest==id_ad1; or
  - an acc reader where some valid checked entry has wr_acc=1.
  - Checked entries are E0 and E1, plus E2 only when WB_BYPASS=0.
- FSM states: IDLE, RUN, DRAIN, HALTED.
- Reset: state=IDLE, tracker all invalid, stall_cnt=0. Outputs in IDLE: pc_en=0, if_id_en=0, pipe_en=1, id_ex_bubble=1, busy=0, halted=0. Reset mid-operation discards all in-flight state identically.
- Output priority within RUN: mem_busy over hazard over issue.
- IDLE:
  - start=1 -> RUN on the next cycle.
- RUN:
  - mem_busy=1: pc_en=0, if_id_en=0, pipe_en=0, id_ex_bubble=0; no state change; stall_cnt unchanged.
  - Else hazard: pc_en=0, if_id_en=0, pipe_en=1, id_ex_bubble=1; stall_cnt += 1, saturating at all-ones.
  - Else issue: pc_en=1, if_id_en=1, pipe_en=1, id_ex_bubble=0. If id_valid and id_opcode==111, go to DRAIN.
  - id_valid=0 issues a NOP entry (invalid) without stalling.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=!mem_busy.
  - When E2.is_hlt=1 and mem_busy=0 -> HALTED.
- HALTED:
  - pc_en=0, if_id_en=0, pipe_en=0, id_ex_bubble=1.
  - resume=1 -> RUN; the tracker is all invalid by then.
- Latency: an instruction issued at cycle t occupies E0 at t+1, E1 at t+2, E2 at t+3.
  - With WB_BYPASS=1, a dependent in ID at t+1 stalls exactly 2 cycles and issues at t+3.
  - With WB_BYPASS=0, it stalls 3 cycles.
- HLT issued at cycle t (no mem_busy): DRAIN from t+1, halted=1 from t+4.
- start or resume asserted outside its owning state: ignored.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN with tracker full -> next cycle state IDLE, pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=1, stall_cnt=0, busy=0, halted=0.
- Register RAW: start; LDO r3 issued at t, STO r3 in ID at t+1 -> id_ex_bubble=1 at t+1 and t+2, STO issues at t+3, stall_cnt=2. With WB_BYPASS=0: 3 stalls, stall_cnt=3.
- Independent ops: LDO r3 then STO r4 -> no stall, pc_en=1 every cycle. PRE r1 then LDM r5 -> LDM stalls 2 cycles (acc hazard), stall_cnt=2.
- HLT drain: NOP, NOP, HLT issued at t -> pc_en=0 from t+1, halted=1 at t+4. Then resume=1 for 1 cycle -> RUN, pc_en=1 the next cycle.
- mem_busy during hazard: ADD r2 stalled behind PRE r2, raise mem_busy 3 cycles -> pipe_en=0, id_ex_bubble=0, stall_cnt frozen. Drop mem_busy -> remaining stall cycles resume; total stall_cnt=2.
- Saturation: preload 4-cycle stall pattern with CNT_W=2 -> stall_cnt reaches 3 and stays 3.
